// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Shared MIPS decode constants, the mult/div FSM state encoding
//               and instruction decode helpers used by the hazard controller.
//               The helpers cover which registers are read and which register
//               is written.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Primary opcodes
    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_JAL   = 6'b000011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_BNE   = 6'b000101;
    localparam logic [5:0] c_OP_LUI   = 6'b001111;
    localparam logic [5:0] c_OP_LB    = 6'b100000;
    localparam logic [5:0] c_OP_LH    = 6'b100001;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_LBU   = 6'b100100;
    localparam logic [5:0] c_OP_LHU   = 6'b100101;
    localparam logic [5:0] c_OP_SB    = 6'b101000;
    localparam logic [5:0] c_OP_SH    = 6'b101001;
    localparam logic [5:0] c_OP_SW    = 6'b101011;

    // R-type function codes
    localparam logic [5:0] c_FN_JR    = 6'b001000;
    localparam logic [5:0] c_FN_JALR  = 6'b001001;
    localparam logic [5:0] c_FN_MFHI  = 6'b010000;
    localparam logic [5:0] c_FN_MTHI  = 6'b010001;
    localparam logic [5:0] c_FN_MFLO  = 6'b010010;
    localparam logic [5:0] c_FN_MTLO  = 6'b010011;
    localparam logic [5:0] c_FN_MULT  = 6'b011000;
    localparam logic [5:0] c_FN_MULTU = 6'b011001;
    localparam logic [5:0] c_FN_DIV   = 6'b011010;
    localparam logic [5:0] c_FN_DIVU  = 6'b011011;

    // Mult/div sequencer states
    typedef enum logic [0:0] {
        MD_IDLE = 1'b0,
        MD_BUSY = 1'b1
    } md_state_t;

    function automatic logic is_rtype(input logic [31:0] instr);
        return instr[31:26] == c_OP_RTYPE;
    endfunction

    function automatic logic is_load(input logic [31:0] instr);
        return (instr[31:26] == c_OP_LW)  || (instr[31:26] == c_OP_LB) ||
               (instr[31:26] == c_OP_LBU) || (instr[31:26] == c_OP_LH) ||
               (instr[31:26] == c_OP_LHU);
    endfunction

    // beq/bne/jr/jalr resolve in D, so they need their operands early
    function automatic logic is_early_branch(input logic [31:0] instr);
        return (instr[31:26] == c_OP_BEQ) || (instr[31:26] == c_OP_BNE) ||
               (is_rtype(instr) &&
                ((instr[5:0] == c_FN_JR) || (instr[5:0] == c_FN_JALR)));
    endfunction

    // mult/multu/div/divu: the ops that launch the mult/div unit
    function automatic logic is_md_start(input logic [31:0] instr);
        return is_rtype(instr) && (instr[5:2] == 4'b0110);
    endfunction

    function automatic logic is_div(input logic [31:0] instr);
        return is_rtype(instr) && (instr[5:1] == 5'b01101);
    endfunction

    // Any op touching the unit or HI/LO: the four starters plus mfhi/mflo/mthi/mtlo
    function automatic logic is_md_op(input logic [31:0] instr);
        return is_md_start(instr) ||
               (is_rtype(instr) && (instr[5:2] == 4'b0100));
    endfunction

    function automatic logic reads_rs(input logic [31:0] instr);
        logic w_skip;
        w_skip = (instr[31:26] == c_OP_J) || (instr[31:26] == c_OP_JAL) ||
                 (instr[31:26] == c_OP_LUI) ||
                 (is_rtype(instr) &&
                  ((instr[5:0] == c_FN_MFHI) || (instr[5:0] == c_FN_MFLO)));
        return !w_skip;
    endfunction

    function automatic logic reads_rt(input logic [31:0] instr);
        logic w_r_ok;
        w_r_ok = is_rtype(instr) &&
                 !((instr[5:0] == c_FN_JR)   || (instr[5:0] == c_FN_JALR) ||
                   (instr[5:0] == c_FN_MFHI) || (instr[5:0] == c_FN_MFLO) ||
                   (instr[5:0] == c_FN_MTHI) || (instr[5:0] == c_FN_MTLO));
        return w_r_ok ||
               (instr[31:26] == c_OP_BEQ) || (instr[31:26] == c_OP_BNE) ||
               (instr[31:26] == c_OP_SW)  || (instr[31:26] == c_OP_SH) ||
               (instr[31:26] == c_OP_SB);
    endfunction

    // Destination register; 0 doubles as "no destination" since $0 never hazards
    function automatic logic [4:0] dest_reg(input logic [31:0] instr);
        logic [4:0] w_dst;
        w_dst = 5'd0;
        if (is_rtype(instr))
            w_dst = instr[15:11];
        else if (instr[31:26] == c_OP_JAL)
            w_dst = 5'd31;
        else if ((instr[31:29] == 3'b001) || is_load(instr))
            w_dst = instr[20:16];
        return w_dst;
    endfunction

    // True when instr reads the (non-zero) register r
    function automatic logic uses_reg(input logic [31:0] instr, input logic [4:0] r);
        return (r != 5'd0) &&
               ((reads_rs(instr) && (instr[25:21] == r)) ||
                (reads_rt(instr) && (instr[20:16] == r)));
    endfunction

endpackage
`default_nettype wire

// File: rtl/md_timer.sv
`default_nettype none
// ============================================================================
// Module      : md_timer
// Description : Mult/div unit occupancy timer. A start pulse loads the latency
//               minus one and enters BUSY; a new start restarts the count.
//               Ports: clk, rst (async, active-high), i_start (launch),
//               i_is_div (select divide latency), o_busy (unit occupied).
// Revision    : 1.0 - initial release
// ============================================================================
module md_timer
    import mips_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic i_start,
    input  logic i_is_div,
    output logic o_busy
);

    localparam int c_MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int c_CNT_W   = (c_MAX_LAT > 1) ? $clog2(c_MAX_LAT) : 1;
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_LAT - 1);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_LAT - 1);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= MD_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        if (i_start) begin
            // Start wins in either state, so back-to-back ops restart the count
            w_state_nxt = MD_BUSY;
            w_cnt_nxt   = i_is_div ? c_DIV_LOAD : c_MULT_LOAD;
        end else begin
            case (r_state)
                MD_IDLE: w_state_nxt = MD_IDLE;
                MD_BUSY: begin
                    if (r_cnt == '0)
                        w_state_nxt = MD_IDLE;
                    else
                        w_cnt_nxt = r_cnt - c_CNT_W'(1);
                end
                default: w_state_nxt = MD_IDLE;
            endcase
        end
    end

    assign o_busy = (r_state == MD_BUSY);

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for a 5-stage MIPS core. Detects
//               load-use, early-branch and mult/div hazards and stalls F/D/E.
//               It also generates the post-reset pipeline clear and counts
//               stall cycles.
//   Clk      in   sole clock, rising edge
//   Reset    in   asynchronous active-high reset
//   InstrD/E/M in 32 instruction words in D/E/M (0 = bubble)
//   Stall    out  stall F/D/E (E inserts bubble)
//   PipeClr  out  synchronous clear for all pipeline registers
//   MdBusy   out  mult/div unit busy
//   MdStart  out  mult/div launch (InstrE is mult/multu/div/divu)
//   StallCnt out 32 saturating count of stalled cycles
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
    import mips_pkg::*;
#(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] InstrD,
    input  logic [31:0] InstrE,
    input  logic [31:0] InstrM,
    output logic        Stall,
    output logic        PipeClr,
    output logic        MdBusy,
    output logic        MdStart,
    output logic [31:0] StallCnt
);

    logic        r_pipe_clr;
    logic [31:0] r_stall_cnt;
    logic [4:0]  w_e_load_rt;
    logic [4:0]  w_e_dest;
    logic [4:0]  w_m_load_rt;
    logic        w_load_use;
    logic        w_branch;
    logic        w_md;
    logic        w_stall;

    // Loads only matter through rt; a zero register drops out inside uses_reg
    assign w_e_load_rt = is_load(InstrE) ? InstrE[20:16] : 5'd0;
    assign w_e_dest    = dest_reg(InstrE);
    assign w_m_load_rt = is_load(InstrM) ? InstrM[20:16] : 5'd0;

    assign w_load_use = uses_reg(InstrD, w_e_load_rt);
    assign w_branch   = is_early_branch(InstrD) &&
                        (uses_reg(InstrD, w_e_dest) || uses_reg(InstrD, w_m_load_rt));
    assign w_md       = is_md_op(InstrD) && (MdBusy || MdStart);

    // A clearing pipeline holds nothing worth stalling for
    assign w_stall = !r_pipe_clr && (w_load_use || w_branch || w_md);

    assign MdStart = is_md_start(InstrE);

    md_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_md_timer (
        .clk      (Clk),
        .rst      (Reset),
        .i_start  (MdStart),
        .i_is_div (is_div(InstrE)),
        .o_busy   (MdBusy)
    );

    // Held high through reset and for the first edge after release
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_pipe_clr <= 1'b1;
        else
            r_pipe_clr <= 1'b0;
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            r_stall_cnt <= '0;
        else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF))
            r_stall_cnt <= r_stall_cnt + 32'd1;
    end

    assign Stall    = w_stall;
    assign PipeClr  = r_pipe_clr;
    assign StallCnt = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Scoreboard bench for hazard_ctrl: directed hazard scenarios
//               followed by random instruction streams, compared against a
//               cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] InstrD = '0;
    logic [31:0] InstrE = '0;
    logic [31:0] InstrM = '0;
    logic        Stall;
    logic        PipeClr;
    logic        MdBusy;
    logic        MdStart;
    logic [31:0] StallCnt;

    hazard_ctrl #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .InstrD   (InstrD),
        .InstrE   (InstrE),
        .InstrM   (InstrM),
        .Stall    (Stall),
        .PipeClr  (PipeClr),
        .MdBusy   (MdBusy),
        .MdStart  (MdStart),
        .StallCnt (StallCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       tag;
        bit          stall;
        bit          mdstart;
        bit          mdbusy;
        bit          pclr;
        logic [31:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state
    int      m_busy_left = 0;  // remaining cycles the unit reports busy
    longint  m_cnt = 0;
    bit      m_pclr_pend = 1;

    // ---------------- reference decode, straight from the ISA rules ----------
    typedef struct {
        bit rd_rs;
        bit rd_rt;
        int dst;     // 0 = none
        bit ld;
        bit brj;     // beq/bne/jr/jalr
        bit mdst;    // mult/multu/div/divu
        bit mdop;    // any HI/LO or mult/div op
        bit dv;
    } dec_t;

    function automatic dec_t decode(input logic [31:0] x);
        dec_t d;
        int op, fn;
        op = int'(x[31:26]);
        fn = int'(x[5:0]);
        d = '{default: 0};
        d.ld  = (op == 'h23) || (op == 'h20) || (op == 'h24) || (op == 'h21) || (op == 'h25);
        d.rd_rs = !((op == 2) || (op == 3) || (op == 'h0f) ||
                    (op == 0 && (fn == 'h10 || fn == 'h12)));
        if (op == 0) begin
            d.rd_rt = !(fn == 8 || fn == 9 || fn == 'h10 || fn == 'h12 || fn == 'h11 || fn == 'h13);
            d.dst   = int'(x[15:11]);
            d.brj   = (fn == 8 || fn == 9);
            d.mdst  = (fn >= 'h18 && fn <= 'h1b);
            d.dv    = (fn == 'h1a || fn == 'h1b);
            d.mdop  = d.mdst || (fn >= 'h10 && fn <= 'h13);
        end else begin
            d.rd_rt = (op == 4) || (op == 5) || (op == 'h2b) || (op == 'h29) || (op == 'h28);
            d.brj   = (op == 4) || (op == 5);
            if (op == 3)
                d.dst = 31;
            else if ((op >= 8 && op <= 'h0f) || d.ld)
                d.dst = int'(x[20:16]);
        end
        return d;
    endfunction

    function automatic bit reads(input logic [31:0] x, input int r);
        dec_t d;
        d = decode(x);
        if (r == 0) return 0;
        return (d.rd_rs && int'(x[25:21]) == r) || (d.rd_rt && int'(x[20:16]) == r);
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input string fld, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h at %0t", tag, fld, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk(e.tag, "Stall",    32'(Stall),   32'(e.stall));
                chk(e.tag, "MdStart",  32'(MdStart), 32'(e.mdstart));
                chk(e.tag, "MdBusy",   32'(MdBusy),  32'(e.mdbusy));
                chk(e.tag, "PipeClr",  32'(PipeClr), 32'(e.pclr));
                chk(e.tag, "StallCnt", StallCnt,     e.cnt);
            end
        end
    end

    // ---------------- stimulus + model ----------------
    task automatic cycle(input string tag, input bit rst_i, input logic [31:0] d,
                         input logic [31:0] e, input logic [31:0] m, input bit frc);
        exp_t  x;
        dec_t  dd, de, dm;
        bit    lu, br, md;
        @(negedge Clk);
        Reset  = rst_i;
        InstrD = d;
        InstrE = e;
        InstrM = m;
        if (frc) begin
            force dut.r_stall_cnt = 32'hFFFF_FFFE;
            m_cnt = 64'hFFFF_FFFE;
        end
        dd = decode(d);
        de = decode(e);
        dm = decode(m);
        if (rst_i) begin
            m_busy_left = 0;
            m_cnt       = 0;
            m_pclr_pend = 1;
        end
        x.tag     = tag;
        x.pclr    = rst_i || m_pclr_pend;
        x.mdstart = de.mdst;
        x.mdbusy  = (m_busy_left > 0);
        lu = de.ld && reads(d, int'(e[20:16]));
        br = dd.brj && (reads(d, de.dst) || (dm.ld && reads(d, int'(m[20:16]))));
        md = dd.mdop && (x.mdbusy || x.mdstart);
        x.stall   = !x.pclr && (lu || br || md);
        x.cnt     = m_cnt[31:0];
        exp_q.push_back(x);
        if (frc) begin
            #1;
            release dut.r_stall_cnt;
        end
        // effect of the coming rising edge
        if (!rst_i) begin
            if (x.stall && m_cnt < 64'hFFFF_FFFF) m_cnt++;
            if (de.mdst) m_busy_left = de.dv ? DIV_LAT : MULT_LAT;
            else if (m_busy_left > 0) m_busy_left--;
            m_pclr_pend = 0;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        int k;
        rs  = 5'($urandom_range(0, 3));
        rt  = 5'($urandom_range(0, 3));
        rd  = 5'($urandom_range(0, 3));
        imm = 16'($urandom);
        k   = $urandom_range(0, 15);
        case (k)
            0:  return 32'h0;
            1:  return {6'h23, rs, rt, imm};
            2:  return {6'h20, rs, rt, imm};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            4:  return {6'h04, rs, rt, imm};
            5:  return {6'h05, rs, rt, imm};
            6:  return {6'h00, rs, 15'd0, 6'h08};
            7:  return {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
            8:  return {6'h00, rs, rt, 10'd0, 6'h18};
            9:  return {6'h00, rs, rt, 10'd0, 6'h1b};
            10: return {6'h00, 10'd0, rd, 5'd0, 6'h12};
            11: return {6'h00, rs, 15'd0, 6'h11};
            12: return {6'h08, rs, rt, imm};
            13: return {6'h2b, rs, rt, imm};
            14: return {6'h03, 10'($urandom), imm};
            default: return {6'h0f, 5'd0, rt, imm};
        endcase
    endfunction

    localparam logic [31:0] LW8   = 32'h8D28_0000;
    localparam logic [31:0] ADD8  = 32'h0108_5020;
    localparam logic [31:0] ADDU  = 32'h0022_5021;
    localparam logic [31:0] BEQ10 = 32'h1140_0004;
    localparam logic [31:0] MULT  = 32'h0109_0018;
    localparam logic [31:0] MFLO  = 32'h0000_5012;
    localparam logic [31:0] DIV   = 32'h0109_001A;

    initial begin : driver
        // reset state and post-reset clear
        cycle("reset",      1, 0, 0, 0, 0);
        cycle("reset",      1, LW8, MULT, 0, 0);
        cycle("release",    0, 0, 0, 0, 0);
        cycle("idle",       0, 0, 0, 0, 0);
        // load-use
        cycle("loaduse",    0, ADD8, LW8, 0, 0);
        cycle("loaduse_ok", 0, ADD8, 0, LW8, 0);
        // branch against E destination, then M non-load
        cycle("branch",     0, BEQ10, ADDU, 0, 0);
        cycle("branch_ok",  0, BEQ10, 0, ADDU, 0);
        // branch against M load
        cycle("branch_mld", 0, 32'h1100_0004, 0, LW8, 0);
        // mult followed by mflo, from a clean counter
        cycle("md_rst",     1, 0, 0, 0, 0);
        cycle("md_rel",     0, 0, 0, 0, 0);
        cycle("mult",       0, MFLO, MULT, 0, 0);
        for (int i = 0; i < 6; i++) cycle("mflo_wait", 0, MFLO, 0, MULT, 0);
        cycle("mflo_go",    0, 0, MFLO, 0, 0);
        // reset during the third busy cycle of a divide
        cycle("div",        0, 0, DIV, 0, 0);
        cycle("div_busy",   0, 0, 0, DIV, 0);
        cycle("div_busy",   0, MFLO, 0, 0, 0);
        cycle("div_reset",  1, MFLO, 0, 0, 0);
        cycle("div_rel",    0, MFLO, 0, 0, 0);
        cycle("div_after",  0, MFLO, 0, 0, 0);
        // saturation
        cycle("sat",        0, ADD8, LW8, 0, 1);
        cycle("sat",        0, ADD8, LW8, 0, 0);
        cycle("sat",        0, ADD8, LW8, 0, 0);
        cycle("sat_hold",   0, 0, 0, 0, 0);
        // randomized streams with occasional reset
        for (int i = 0; i < 400; i++)
            cycle("random", ($urandom_range(0, 49) == 0), rand_instr(), rand_instr(),
                  rand_instr(), 0);
        @(negedge Clk);
        #5;
        chk("drain", "queue", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
